regfile_writeback: RTL and testbench



---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 72 +++++++
 rtl/regfile_writeback.sv | 169 ++++++++++++++++
 tb/tb_regfile_writeback.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and sizes for the register-file write-back block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    // Which path produced the write currently on the register-file port.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2
    } wb_src_e;

    // One buffered load result: destination register plus data.
    typedef struct packed {
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   rd_data;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage : wb_pkg

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding load results until the write port is free.
// Latency: an entry pushed at edge N is visible at head_o from cycle N+1.
// Backpressure: full_o stops the producer; a push while full is taken only with a pop.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 5 + XLEN
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             push_eff;
    logic             pop_eff;

    assign full_o   = (count_q == (AW+1)'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign head_o   = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pop_eff  = pop_i && !empty_o;
    assign push_eff = push_i && (!full_o || pop_eff);

    // Occupancy next-state.
    always_comb begin
        count_d = count_q;
        if (push_eff && !pop_eff) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_eff && !push_eff) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointers and occupancy; reset discards every in-flight entry.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clock_i) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule : wb_fifo

// File: rtl/regfile_writeback.sv
// Merges ALU and load results onto the single register-file write port; tracks pending loads.
// Latency: ALU result 1 cycle to rd_wren_o; load result 2 cycles (through the FIFO) when the port is free.
// Backpressure: alu_ready_o and mem_ready_o both drop while the load FIFO is full.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int MEM_FIFO_DEPTH = 2
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [REG_AW-1:0] alu_rd_addr_i,
    input  logic [XLEN-1:0]   alu_rd_data_i,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic [REG_AW-1:0] mem_rd_addr_i,
    input  logic [XLEN-1:0]   mem_rd_data_i,
    input  logic              issue_valid_i,
    input  logic              issue_load_i,
    input  logic [REG_AW-1:0] issue_rd_addr_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic [XLEN-1:0]   rd_data_o,
    output logic              rd_wren_o
);

    wb_entry_t         fifo_in;
    wb_entry_t         fifo_head;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;

    wb_src_e           sel_src;

    logic              rd_wren_d;
    logic              rd_wren_q;
    logic [REG_AW-1:0] rd_addr_d;
    logic [REG_AW-1:0] rd_addr_q;
    logic [XLEN-1:0]   rd_data_d;
    logic [XLEN-1:0]   rd_data_q;
    wb_src_e           src_d;
    wb_src_e           src_q;

    logic [NREG-1:0]   busy_d;
    logic [NREG-1:0]   busy_q;
    logic              ld_clr;
    logic              ld_set;

    // Both producers stall on a full FIFO: the full FIFO owns the port that cycle.
    assign mem_ready_o = !fifo_full;
    assign alu_ready_o = !fifo_full;

    assign fifo_push       = mem_valid_i && mem_ready_o;
    assign fifo_in.rd_addr = mem_rd_addr_i;
    assign fifo_in.rd_data = mem_rd_data_i;

    wb_fifo #(
        .DEPTH (MEM_FIFO_DEPTH),
        .WIDTH (WB_ENTRY_W)
    ) u_load_fifo (
        .clock_i    (clock_i),
        .reset_ni   (reset_ni),
        .push_i     (fifo_push),
        .push_dat_i (fifo_in),
        .pop_i      (fifo_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (fifo_head)
    );

    // Port arbitration: a full FIFO drains first so loads cannot starve,
    // otherwise a real ALU write wins, otherwise any buffered load goes.
    // An ALU result to x0 never claims the port.
    always_comb begin
        sel_src  = WB_NONE;
        fifo_pop = 1'b0;
        if (fifo_full) begin
            sel_src  = WB_MEM;
            fifo_pop = 1'b1;
        end else if (alu_valid_i && (alu_rd_addr_i != '0)) begin
            sel_src = WB_ALU;
        end else if (!fifo_empty) begin
            sel_src  = WB_MEM;
            fifo_pop = 1'b1;
        end
    end

    // Next write-port contents; an idle port (including a popped x0 load)
    // presents address 0 / data 0 so register-file forwarding stays harmless.
    always_comb begin
        rd_wren_d = 1'b0;
        rd_addr_d = '0;
        rd_data_d = '0;
        src_d     = WB_NONE;
        case (sel_src)
            WB_ALU: begin
                rd_wren_d = 1'b1;
                rd_addr_d = alu_rd_addr_i;
                rd_data_d = alu_rd_data_i;
                src_d     = WB_ALU;
            end
            WB_MEM: begin
                if (fifo_head.rd_addr != '0) begin
                    rd_wren_d = 1'b1;
                    rd_addr_d = fifo_head.rd_addr;
                    rd_data_d = fifo_head.rd_data;
                    src_d     = WB_MEM;
                end
            end
            default: begin
            end
        endcase
    end

    // Registered write port towards the register file.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_wren_q <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            src_q     <= WB_NONE;
        end else begin
            rd_wren_q <= rd_wren_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            src_q     <= src_d;
        end
    end

    assign rd_wren_o = rd_wren_q;
    assign rd_addr_o = rd_addr_q;
    assign rd_data_o = rd_data_q;

    // A load write on the port this cycle retires its pending bit at the next edge.
    assign ld_clr = rd_wren_q && (src_q == WB_MEM);
    assign ld_set = issue_valid_i && issue_load_i && (issue_rd_addr_i != '0);

    // Pending-load scoreboard next-state; a new load to the same register overrides the retire.
    always_comb begin
        busy_d = busy_q;
        if (ld_clr) begin
            busy_d[rd_addr_q] = 1'b0;
        end
        if (ld_set) begin
            busy_d[issue_rd_addr_i] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A source being written by its load this cycle is already forwardable, so it is not busy.
    assign rs1_busy_o = (rs1_addr_i != '0) && busy_q[rs1_addr_i] &&
                        !(ld_clr && (rd_addr_q == rs1_addr_i));
    assign rs2_busy_o = (rs2_addr_i != '0) && busy_q[rs2_addr_i] &&
                        !(ld_clr && (rd_addr_q == rs2_addr_i));

endmodule : regfile_writeback

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed cases plus randomized traffic against a queue-based model.
// Latency: n/a.
// Backpressure: ALU and load drivers hold their result until accepted.
module tb_regfile_writeback;

    logic        clock_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        alu_valid_i = 1'b0;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_addr_i = '0;
    logic [31:0] alu_rd_data_i = '0;
    logic        mem_valid_i = 1'b0;
    logic        mem_ready_o;
    logic [4:0]  mem_rd_addr_i = '0;
    logic [31:0] mem_rd_data_i = '0;
    logic        issue_valid_i = 1'b0;
    logic        issue_load_i = 1'b0;
    logic [4:0]  issue_rd_addr_i = '0;
    logic [4:0]  rs1_addr_i = '0;
    logic [4:0]  rs2_addr_i = '0;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wren_o;

    regfile_writeback #(.MEM_FIFO_DEPTH(2)) dut (
        .clock_i         (clock_i),
        .reset_ni        (reset_ni),
        .alu_valid_i     (alu_valid_i),
        .alu_ready_o     (alu_ready_o),
        .alu_rd_addr_i   (alu_rd_addr_i),
        .alu_rd_data_i   (alu_rd_data_i),
        .mem_valid_i     (mem_valid_i),
        .mem_ready_o     (mem_ready_o),
        .mem_rd_addr_i   (mem_rd_addr_i),
        .mem_rd_data_i   (mem_rd_data_i),
        .issue_valid_i   (issue_valid_i),
        .issue_load_i    (issue_load_i),
        .issue_rd_addr_i (issue_rd_addr_i),
        .rs1_addr_i      (rs1_addr_i),
        .rs2_addr_i      (rs2_addr_i),
        .rs1_busy_o      (rs1_busy_o),
        .rs2_busy_o      (rs2_busy_o),
        .rd_addr_o       (rd_addr_o),
        .rd_data_o       (rd_data_o),
        .rd_wren_o       (rd_wren_o)
    );

    always #5 clock_i = ~clock_i;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    // Expected writes, each stream in acceptance order.
    exp_t       alu_q[$];
    exp_t       mem_q[$];
    // Reference pending-load set: registers with an outstanding load.
    bit         busy_m[32];
    // Destinations of issued loads not yet returned by the load driver.
    logic [4:0] load_q[$];
    bit         alu_acc;
    bit         mem_acc;
    bit         mon_is_ld;
    bit         exp_busy;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock_i);
        #1;
    endtask

    // Scoreboard monitor: compares the write port and busy outputs each cycle,
    // then records accepted results and advances the pending-load model.
    always @(negedge clock_i) begin
        if (!reset_ni) begin
            alu_q.delete();
            mem_q.delete();
            foreach (busy_m[i]) busy_m[i] = 1'b0;
            alu_acc = 1'b0;
            mem_acc = 1'b0;
        end else begin
            mon_is_ld = 1'b0;
            if (rd_wren_o) begin
                n_checks++;
                if (mem_q.size() > 0 && mem_q[0].a == rd_addr_o && mem_q[0].d == rd_data_o) begin
                    void'(mem_q.pop_front());
                    mon_is_ld = 1'b1;
                end else if (alu_q.size() > 0 && alu_q[0].a == rd_addr_o && alu_q[0].d == rd_data_o) begin
                    void'(alu_q.pop_front());
                end else begin
                    n_fail++;
                    $display("FAIL wb_write: got x%0d=0x%08h, not the next ALU or load result at %0t",
                             rd_addr_o, rd_data_o, $time);
                end
            end else begin
                check("idle_addr", 32'(rd_addr_o), 32'd0);
                check("idle_data", rd_data_o, 32'd0);
            end
            exp_busy = (rs1_addr_i != 0) && busy_m[rs1_addr_i] && !(mon_is_ld && rd_addr_o == rs1_addr_i);
            check("rs1_busy", 32'(rs1_busy_o), 32'(exp_busy));
            exp_busy = (rs2_addr_i != 0) && busy_m[rs2_addr_i] && !(mon_is_ld && rd_addr_o == rs2_addr_i);
            check("rs2_busy", 32'(rs2_busy_o), 32'(exp_busy));

            alu_acc = alu_valid_i && alu_ready_o;
            mem_acc = mem_valid_i && mem_ready_o;
            if (alu_acc && alu_rd_addr_i != 0) alu_q.push_back('{a: alu_rd_addr_i, d: alu_rd_data_i});
            if (mem_acc && mem_rd_addr_i != 0) mem_q.push_back('{a: mem_rd_addr_i, d: mem_rd_data_i});

            if (mon_is_ld) busy_m[rd_addr_o] = 1'b0;
            if (issue_valid_i && issue_load_i && issue_rd_addr_i != 0) busy_m[issue_rd_addr_i] = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- power-on reset ----------------
        repeat (3) @(posedge clock_i);
        #1;
        check("por_wren", 32'(rd_wren_o), 32'd0);
        check("por_addr", 32'(rd_addr_o), 32'd0);
        @(posedge clock_i);
        #3 reset_ni = 1'b1;

        // ---------------- ALU write ----------------
        cyc();
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd5; alu_rd_data_i = 32'hDEADBEEF;
        cyc();
        alu_valid_i = 1'b0;
        #1;
        check("alu_wren", 32'(rd_wren_o), 32'd1);
        check("alu_addr", 32'(rd_addr_o), 32'd5);
        check("alu_data", rd_data_o, 32'hDEADBEEF);
        cyc(); #1;
        check("alu_idle_wren", 32'(rd_wren_o), 32'd0);
        check("alu_idle_addr", 32'(rd_addr_o), 32'd0);

        // ---------------- load scoreboard ----------------
        cyc();
        issue_valid_i = 1'b1; issue_load_i = 1'b1; issue_rd_addr_i = 5'd7; rs1_addr_i = 5'd7;
        #1 check("ld_busy_n0", 32'(rs1_busy_o), 32'd0);
        cyc();
        issue_valid_i = 1'b0; issue_load_i = 1'b0;
        #1 check("ld_busy_n1", 32'(rs1_busy_o), 32'd1);
        cyc(); #1 check("ld_busy_n2", 32'(rs1_busy_o), 32'd1);
        cyc();
        mem_valid_i = 1'b1; mem_rd_addr_i = 5'd7; mem_rd_data_i = 32'h1234;
        #1 check("ld_busy_n3", 32'(rs1_busy_o), 32'd1);
        cyc();
        mem_valid_i = 1'b0;
        #1;
        check("ld_busy_n4", 32'(rs1_busy_o), 32'd1);
        check("ld_wren_n4", 32'(rd_wren_o), 32'd0);
        cyc(); #1;
        check("ld_wren_n5", 32'(rd_wren_o), 32'd1);
        check("ld_addr_n5", 32'(rd_addr_o), 32'd7);
        check("ld_data_n5", rd_data_o, 32'h1234);
        check("ld_busy_n5", 32'(rs1_busy_o), 32'd0);
        cyc(); #1;
        check("ld_busy_n6", 32'(rs1_busy_o), 32'd0);

        // ---------------- ALU / load conflict ----------------
        cyc();
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd3; alu_rd_data_i = 32'hAAAA0003;
        mem_valid_i = 1'b1; mem_rd_addr_i = 5'd4; mem_rd_data_i = 32'hBBBB0004;
        cyc();
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        #1;
        check("cf_addr_n1", 32'(rd_addr_o), 32'd3);
        check("cf_data_n1", rd_data_o, 32'hAAAA0003);
        cyc(); #1;
        check("cf_addr_n2", 32'(rd_addr_o), 32'd4);
        check("cf_data_n2", rd_data_o, 32'hBBBB0004);
        cyc(); #1;
        check("cf_idle", 32'(rd_wren_o), 32'd0);

        // ---------------- backpressure ----------------
        cyc();
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd9; alu_rd_data_i = 32'hA1A1A1A1;
        mem_valid_i = 1'b1; mem_rd_addr_i = 5'd10; mem_rd_data_i = 32'h10101010;
        cyc();
        alu_rd_data_i = 32'hA2A2A2A2;
        mem_rd_addr_i = 5'd11; mem_rd_data_i = 32'h11111111;
        #1 check("bp_c1_data", rd_data_o, 32'hA1A1A1A1);
        cyc();
        alu_rd_data_i = 32'hA3A3A3A3;
        mem_valid_i = 1'b0;
        #1;
        check("bp_mem_ready", 32'(mem_ready_o), 32'd0);
        check("bp_alu_ready", 32'(alu_ready_o), 32'd0);
        check("bp_c2_data", rd_data_o, 32'hA2A2A2A2);
        cyc(); #1;
        check("bp_c3_addr", 32'(rd_addr_o), 32'd10);
        check("bp_c3_data", rd_data_o, 32'h10101010);
        check("bp_c3_alu_ready", 32'(alu_ready_o), 32'd1);
        cyc();
        alu_valid_i = 1'b0;
        #1;
        check("bp_c4_addr", 32'(rd_addr_o), 32'd9);
        check("bp_c4_data", rd_data_o, 32'hA3A3A3A3);
        cyc(); #1;
        check("bp_c5_addr", 32'(rd_addr_o), 32'd11);
        check("bp_c5_data", rd_data_o, 32'h11111111);
        cyc(); #1;
        check("bp_c6_idle", 32'(rd_wren_o), 32'd0);

        // ---------------- x0 cases ----------------
        cyc();
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd0; alu_rd_data_i = 32'h55555555;
        issue_valid_i = 1'b1; issue_load_i = 1'b1; issue_rd_addr_i = 5'd0; rs1_addr_i = 5'd0;
        cyc();
        alu_valid_i = 1'b0; issue_valid_i = 1'b0; issue_load_i = 1'b0;
        #1;
        check("x0_alu_wren", 32'(rd_wren_o), 32'd0);
        check("x0_alu_addr", 32'(rd_addr_o), 32'd0);
        check("x0_ld_busy", 32'(rs1_busy_o), 32'd0);
        cyc();
        mem_valid_i = 1'b1; mem_rd_addr_i = 5'd0; mem_rd_data_i = 32'h66666666;
        cyc();
        mem_rd_addr_i = 5'd11; mem_rd_data_i = 32'h77777777;
        cyc();
        mem_valid_i = 1'b0;
        #1;
        check("x0_mem_wren", 32'(rd_wren_o), 32'd0);
        check("x0_mem_addr", 32'(rd_addr_o), 32'd0);
        cyc(); #1;
        check("x0_next_wren", 32'(rd_wren_o), 32'd1);
        check("x0_next_addr", 32'(rd_addr_o), 32'd11);
        check("x0_next_data", rd_data_o, 32'h77777777);

        // ---------------- mid-cycle asynchronous reset ----------------
        cyc();
        issue_valid_i = 1'b1; issue_load_i = 1'b1; issue_rd_addr_i = 5'd12;
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd9; alu_rd_data_i = 32'hCAFEF00D;
        mem_valid_i = 1'b1; mem_rd_addr_i = 5'd13; mem_rd_data_i = 32'h13131313;
        cyc();
        issue_valid_i = 1'b0; issue_load_i = 1'b0; alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        rs1_addr_i = 5'd12;
        #1 check("pre_rst_busy", 32'(rs1_busy_o), 32'd1);
        #1 reset_ni = 1'b0;
        #1;
        check("rst_wren", 32'(rd_wren_o), 32'd0);
        check("rst_addr", 32'(rd_addr_o), 32'd0);
        check("rst_data", rd_data_o, 32'd0);
        check("rst_mem_ready", 32'(mem_ready_o), 32'd1);
        check("rst_alu_ready", 32'(alu_ready_o), 32'd1);
        check("rst_busy_x12", 32'(rs1_busy_o), 32'd0);
        for (int a = 0; a < 32; a++) begin
            rs1_addr_i = 5'(a);
            #1 check("rst_busy_all", 32'(rs1_busy_o), 32'd0);
        end
        @(posedge clock_i);
        #3 reset_ni = 1'b1;
        cyc(); #1;
        check("post_rst_wren", 32'(rd_wren_o), 32'd0);

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (!(alu_valid_i && !alu_acc)) begin
                alu_valid_i   = ($urandom_range(0, 2) != 0);
                alu_rd_addr_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                alu_rd_data_i = $urandom;
            end
            if (!(mem_valid_i && !mem_acc)) begin
                if (load_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    mem_valid_i   = 1'b1;
                    mem_rd_addr_i = load_q.pop_front();
                    mem_rd_data_i = $urandom;
                end else begin
                    mem_valid_i = 1'b0;
                end
            end
            issue_valid_i   = ($urandom_range(0, 1) == 1);
            issue_load_i    = ($urandom_range(0, 1) == 1);
            issue_rd_addr_i = 5'($urandom_range(0, 31));
            if (issue_load_i && issue_rd_addr_i != 0 && busy_m[issue_rd_addr_i]) issue_load_i = 1'b0;
            assert (!(issue_valid_i && issue_load_i && issue_rd_addr_i != 0 && busy_m[issue_rd_addr_i]))
                else $error("issue of a load to a busy register");
            if (issue_valid_i && issue_load_i) load_q.push_back(issue_rd_addr_i);
            rs1_addr_i = 5'($urandom_range(0, 31));
            rs2_addr_i = 5'($urandom_range(0, 31));
        end

        // ---------------- drain ----------------
        issue_valid_i = 1'b0;
        issue_load_i  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            cyc();
            if (alu_acc) alu_valid_i = 1'b0;
            if (!(mem_valid_i && !mem_acc)) begin
                if (load_q.size() > 0) begin
                    mem_valid_i   = 1'b1;
                    mem_rd_addr_i = load_q.pop_front();
                    mem_rd_data_i = $urandom;
                end else begin
                    mem_valid_i = 1'b0;
                end
            end
            if (!alu_valid_i && !mem_valid_i && load_q.size() == 0 &&
                alu_q.size() == 0 && mem_q.size() == 0 && c > 4) break;
        end
        cyc(); cyc();
        check("drain_alu_left", 32'(alu_q.size()), 32'd0);
        check("drain_mem_left", 32'(mem_q.size()), 32'd0);
        for (int a = 1; a < 32; a++) begin
            rs1_addr_i = 5'(a);
            #1 check("drain_busy", 32'(rs1_busy_o), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_writeback
